serial_mag_compare: RTL and testbench
=====================================

# serial_mag_compare

Bit-serial magnitude comparator that consumes the per-bit `equal`/`lesser`/`greater` outputs of the existing 1-bit `comparator`, MSB first. It accumulates WIDTH bit results into a word-level verdict for operands A and B. It sits directly downstream of `comparator`: a shifter upstream presents one bit pair per cycle to `comparator`, and this block turns the bit stream into one result per word.

## Interface
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a new word; clears the previous result.
- `bit_valid`  in  1  the `*_in` inputs carry a valid bit result this cycle.
- `equal_in`  in  1  from `comparator`: A bit == B bit.
- `lesser_in`  in  1  from `comparator`: A bit < B bit.
- `greater_in`  in  1  from `comparator`: A bit > B bit.
- `busy`  out  1  high while collecting bits.
- `done`  out  1  one-cycle pulse when the word verdict is final.
- `equal`  out  1  word verdict: A == B; held after `done`.
- `lesser`  out  1  word verdict: A < B; held after `done`.
- `greater`  out  1  word verdict: A > B; held after `done`.
- `err`  out  1  sticky: at least one accepted bit had non-one-hot `*_in`.

## Operation
- States:
  - IDLE: reset state.
  - COLLECT
  - DONE: result held.
- Bit counter: `cnt`, width `$clog2(WIDTH)`. Decision flag: `decided`.
- `start` in any non-reset state:
  - next state COLLECT.
  - `cnt`=0, `decided`=0.
  - `equal`/`lesser`/`greater`=0, `err`=0.
  - `bit_valid` in the same cycle as `start` is ignored.
- COLLECT, `bit_valid`=1 (accepted bit):
  - If `decided`=0 and `lesser_in` is one-hot high: latch lesser, set `decided`.
  - If `decided`=0 and `greater_in` is one-hot high: latch greater, set `decided`.
  - Otherwise the verdict is unchanged. The first differing bit (MSB-first) decides.
  - Non-one-hot inputs (zero or multiple high) set `err`, are treated as equal, and still count as a bit.
  - `cnt` increments.
- COLLECT, `bit_valid`=0: hold everything. Gaps of any length are allowed.
- Final accepted bit (`cnt`==WIDTH-1 and `bit_valid`):
  - next state DONE.
  - Outputs update on that edge: `done`=1 for exactly one cycle.
  - `equal`=1 iff not `decided` after this bit; otherwise exactly one of `lesser`/`greater` is 1.
- DONE:
  - Verdict held indefinitely.
  - `bit_valid` is ignored.
  - `start` restarts the block.
- IDLE: `bit_valid` is ignored and all outputs hold at 0.
- `start` during COLLECT aborts the current word: no `done` pulse, full restart.
- `start` and the final `bit_valid` in the same cycle: `start` wins. No `done`, new word begins.
- `rst` has priority over everything, including mid-word. The block returns to IDLE with reset values.

## Timing
- Reset values:
  - state IDLE, `cnt`=0
  - `busy`=0, `done`=0
  - `equal`=0, `lesser`=0, `greater`=0
  - `err`=0
- All outputs are registered; there is no combinational path from inputs to outputs.
- `busy` rises the cycle after `start` and falls on the same edge that raises `done`.
- Latency: `done` is visible the cycle after the WIDTH-th accepted bit. With back-to-back `bit_valid`, `done` appears WIDTH+1 cycles after `start` is sampled.
- Verdict outputs are 0 until `done` and stay stable from `done` until the next `start` or `rst`.
- Once `done` occurs, exactly one of `equal`/`lesser`/`greater` is high, regardless of `err`.

## Test plan
- Same operands: WIDTH=8, A=B=0xA5, 8 consecutive `equal_in` bits -> `done` pulse 9 cycles after `start`; `equal`=1, `lesser`=0, `greater`=0, `err`=0.
- MSB decides: A=0x80, B=0x7F, MSB-first -> bit 7 is `greater_in`, bits 6..0 are `lesser_in`. Required result: `greater`=1; later bits do not override.
- Late decision with gaps: A=0x12, B=0x13, `bit_valid` dropped for 3 cycles between bits -> bits 7..1 equal, bit 0 `lesser_in`. Required result: `lesser`=1, and `done` is delayed exactly 3 cycles versus the no-gap case.
- Bad input: bit 4 presented with `equal_in`=`lesser_in`=1 -> `err`=1 through `done`. That bit is treated as equal. The next `start` clears `err`.
- Abort: `start` after 5 bits, then 8 fresh bits of A=0x01, B=0x00 -> single `done`, `greater`=1. No `done` pulse for the aborted word.
- Reset mid-word: `rst` after 3 bits -> next cycle all outputs 0, state IDLE. Subsequent `bit_valid` without `start` produces no `done`.

Source files
------------

// File: rtl/serial_mag_compare.sv
// Bit-serial magnitude comparator: folds MSB-first per-bit comparator results
// into one registered equal/lesser/greater verdict per WIDTH-bit word.
module serial_mag_compare #(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic bit_valid,
   input  logic equal_in,
   input  logic lesser_in,
   input  logic greater_in,
   output logic busy,
   output logic done,
   output logic equal,
   output logic lesser,
   output logic greater,
   output logic err
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             decided, decided_nxt;
   logic             dir_lt, dir_lt_nxt;
   logic             busy_nxt, done_nxt;
   logic             equal_nxt, lesser_nxt, greater_nxt, err_nxt;

   logic [1:0]       hot_cnt_c;
   logic             one_hot_c;
   logic             dec_now_c, lt_now_c;

   // A bit result is trusted only when exactly one comparator output is high.
   assign hot_cnt_c = 2'(equal_in) + 2'(lesser_in) + 2'(greater_in);
   assign one_hot_c = (hot_cnt_c == 2'd1);

   // Decision state including the bit currently presented.
   always_comb begin
      dec_now_c = decided;
      lt_now_c  = dir_lt;
      if (!decided && one_hot_c && lesser_in) begin
         dec_now_c = 1'b1;
         lt_now_c  = 1'b1;
      end else if (!decided && one_hot_c && greater_in) begin
         dec_now_c = 1'b1;
         lt_now_c  = 1'b0;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      decided_nxt = decided;
      dir_lt_nxt  = dir_lt;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      equal_nxt   = equal;
      lesser_nxt  = lesser;
      greater_nxt = greater;
      err_nxt     = err;

      if (start) begin
         // start wins over any bit presented in the same cycle
         state_nxt   = S_COLLECT;
         cnt_nxt     = '0;
         decided_nxt = 1'b0;
         dir_lt_nxt  = 1'b0;
         busy_nxt    = 1'b1;
         equal_nxt   = 1'b0;
         lesser_nxt  = 1'b0;
         greater_nxt = 1'b0;
         err_nxt     = 1'b0;
      end else begin
         unique case (state)
            S_COLLECT: begin
               if (bit_valid) begin
                  decided_nxt = dec_now_c;
                  dir_lt_nxt  = lt_now_c;
                  if (!one_hot_c) begin
                     err_nxt = 1'b1;
                  end
                  if (cnt == LAST_CNT) begin
                     state_nxt   = S_DONE;
                     busy_nxt    = 1'b0;
                     done_nxt    = 1'b1;
                     equal_nxt   = !dec_now_c;
                     lesser_nxt  = dec_now_c && lt_now_c;
                     greater_nxt = dec_now_c && !lt_now_c;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end
            end
            S_IDLE, S_DONE: begin
               state_nxt = state;
            end
            default: begin
               state_nxt = S_IDLE;
               busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         decided <= 1'b0;
         dir_lt  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         equal   <= 1'b0;
         lesser  <= 1'b0;
         greater <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         decided <= decided_nxt;
         dir_lt  <= dir_lt_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         equal   <= equal_nxt;
         lesser  <= lesser_nxt;
         greater <= greater_nxt;
         err     <= err_nxt;
      end
   end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Self-checking bench for serial_mag_compare: vector table plus hand-written
// abort / start-collision / reset sequences, checked through a done scoreboard.
module tb_serial_mag_compare;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst, start, bit_valid, equal_in, lesser_in, greater_in;
   logic busy, done, equal, lesser, greater, err;

   serial_mag_compare #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
      .equal_in(equal_in), .lesser_in(lesser_in), .greater_in(greater_in),
      .busy(busy), .done(done), .equal(equal), .lesser(lesser),
      .greater(greater), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      int         bad_bit;   // bit index given non-one-hot inputs, -1 none
      int         bad_kind;  // 1: eq+lt, 2: none high, 3: lt+gt
      int         gap_after; // bits sent before the gap
      int         gap_len;
      logic       eq, lt, gt, er;
   } vec_t;

   typedef struct {
      logic eq, lt, gt, er;
      int   lat;
      int   start_cyc;
   } exp_t;

   vec_t tbl[9];
   exp_t sb[$];
   exp_t mon_r;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   done_seen = 0;
   logic prev_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Scoreboard consumer: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         done_seen++;
         chk("done_single_cycle", int'(prev_done), 0);
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            mon_r = sb.pop_front();
            chk("equal", int'(equal), int'(mon_r.eq));
            chk("lesser", int'(lesser), int'(mon_r.lt));
            chk("greater", int'(greater), int'(mon_r.gt));
            chk("err", int'(err), int'(mon_r.er));
            chk("busy_at_done", int'(busy), 0);
            chk("latency", cyc - mon_r.start_cyc + 1, mon_r.lat);
         end
      end
      prev_done = done;
   end

   task automatic cyc1();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                               input int bb, input int bk, input int ga,
                               input int gl, input logic eq, input logic lt,
                               input logic gt, input logic er);
      vec_t v;
      v.a = a; v.b = b; v.bad_bit = bb; v.bad_kind = bk;
      v.gap_after = ga; v.gap_len = gl;
      v.eq = eq; v.lt = lt; v.gt = gt; v.er = er;
      return v;
   endfunction

   task automatic set_bit(input logic [7:0] a, input logic [7:0] b, input int i,
                          input int bb, input int bk);
      logic x, y;
      x = a[i];
      y = b[i];
      equal_in   = (x == y);
      lesser_in  = !x && y;
      greater_in = x && !y;
      if (i == bb) begin
         case (bk)
            1: begin equal_in = 1'b1; lesser_in = 1'b1; greater_in = 1'b0; end
            2: begin equal_in = 1'b0; lesser_in = 1'b0; greater_in = 1'b0; end
            3: begin equal_in = 1'b0; lesser_in = 1'b1; greater_in = 1'b1; end
            default: ;
         endcase
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 30) begin
         cyc1();
         n++;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", 1, 0);
         sb.delete();
      end
   endtask

   // Drives one full word; start_bv also presents a bit in the start cycle.
   task automatic run_vec(input vec_t v, input logic start_bv);
      exp_t e;
      int   sent;
      start = 1'b1;
      bit_valid = start_bv;
      set_bit(v.a, v.b, 0, -1, 0);
      cyc1();
      start = 1'b0;
      chk("clear_err", int'(err), 0);
      chk("clear_verdict", int'({equal, lesser, greater}), 0);
      chk("busy_after_start", int'(busy), 1);
      e.eq = v.eq; e.lt = v.lt; e.gt = v.gt; e.er = v.er;
      e.lat = int'(W) + 1 + ((v.gap_after > 0 && v.gap_after < int'(W)) ? v.gap_len : 0);
      e.start_cyc = cyc;
      sb.push_back(e);
      sent = 0;
      for (int i = int'(W) - 1; i >= 0; i--) begin
         set_bit(v.a, v.b, i, v.bad_bit, v.bad_kind);
         bit_valid = 1'b1;
         cyc1();
         sent++;
         if (sent == v.gap_after && v.gap_len > 0) begin
            bit_valid = 1'b0;
            repeat (v.gap_len) cyc1();
         end
      end
      bit_valid = 1'b0;
      drain();
   endtask

   // Starts a word and feeds only n bits, leaving it unfinished.
   task automatic partial(input logic [7:0] a, input logic [7:0] b, input int n);
      start = 1'b1;
      bit_valid = 1'b0;
      cyc1();
      start = 1'b0;
      for (int k = 0; k < n; k++) begin
         set_bit(a, b, int'(W) - 1 - k, -1, 0);
         bit_valid = 1'b1;
         cyc1();
      end
      bit_valid = 1'b0;
   endtask

   initial begin
      int d0;
      tbl[0] = mk(8'hA5, 8'hA5, -1, 0, 0, 0, 1, 0, 0, 0);
      tbl[1] = mk(8'h80, 8'h7F, -1, 0, 0, 0, 0, 0, 1, 0);
      tbl[2] = mk(8'h12, 8'h13, -1, 0, 4, 3, 0, 1, 0, 0);
      tbl[3] = mk(8'h3C, 8'h3C, 4, 1, 0, 0, 1, 0, 0, 1);
      tbl[4] = mk(8'h00, 8'hFF, -1, 0, 0, 0, 0, 1, 0, 0);
      tbl[5] = mk(8'hFF, 8'hFE, -1, 0, 0, 0, 0, 0, 1, 0);
      tbl[6] = mk(8'h55, 8'h54, 7, 2, 0, 0, 0, 0, 1, 1);
      tbl[7] = mk(8'h12, 8'h13, -1, 0, 0, 0, 0, 1, 0, 0);
      tbl[8] = mk(8'h40, 8'h00, 7, 3, 0, 0, 0, 0, 1, 1);

      rst = 1'b1; start = 1'b0; bit_valid = 1'b0;
      equal_in = 1'b0; lesser_in = 1'b0; greater_in = 1'b0;
      repeat (3) cyc1();
      chk("reset_outputs", int'({busy, done, equal, lesser, greater, err}), 0);
      rst = 1'b0;

      // IDLE ignores bits entirely
      bit_valid = 1'b1; equal_in = 1'b1;
      repeat (12) cyc1();
      bit_valid = 1'b0;
      chk("idle_no_done", done_seen, 0);
      chk("idle_outputs", int'({busy, equal, lesser, greater, err}), 0);

      for (int t = 0; t < 9; t++) begin
         run_vec(tbl[t], 1'b0);
         // verdict holds in DONE while bits keep arriving
         d0 = done_seen;
         bit_valid = 1'b1; lesser_in = 1'b1; equal_in = 1'b0; greater_in = 1'b0;
         repeat (4) cyc1();
         bit_valid = 1'b0;
         chk("hold_verdict", int'({equal, lesser, greater}),
             int'({tbl[t].eq, tbl[t].lt, tbl[t].gt}));
         chk("hold_err", int'(err), int'(tbl[t].er));
         chk("hold_no_done", done_seen, d0);
      end

      // abort after 5 bits of an already-decided word
      d0 = done_seen;
      partial(8'h00, 8'hFF, 5);
      chk("abort_busy", int'(busy), 1);
      run_vec(mk(8'h01, 8'h00, -1, 0, 0, 0, 0, 0, 1, 0), 1'b0);
      chk("abort_single_done", done_seen - d0, 1);

      // start collides with the final bit: start wins
      d0 = done_seen;
      partial(8'h00, 8'hFF, int'(W) - 1);
      run_vec(tbl[0], 1'b1);
      chk("collide_single_done", done_seen - d0, 1);

      // reset mid-word
      d0 = done_seen;
      partial(8'h80, 8'h00, 3);
      rst = 1'b1;
      cyc1();
      rst = 1'b0;
      chk("midreset_outputs", int'({busy, done, equal, lesser, greater, err}), 0);
      bit_valid = 1'b1; equal_in = 1'b1; lesser_in = 1'b0; greater_in = 1'b0;
      repeat (12) cyc1();
      bit_valid = 1'b0;
      cyc1();
      chk("midreset_no_done", done_seen - d0, 0);
      chk("midreset_idle", int'(busy), 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
